jk_reg_bank: RTL and testbench

Parametrised multi-mode flip-flop register bank. It holds WIDTH independent state bits that update on the rising clock edge. A run-time mode selects D, T, JK or SR next-state semantics for all bits at once. The bank also reports a per-bit change strobe and a sticky SR-conflict flag. It is the general-purpose state-holding primitive for the sequential-circuit library and succeeds the single-bit JK flip-flop with vector width, mode selection, enable and status reporting.

---
 rtl/ff_pkg.sv | 11 +
 rtl/jk_reg_bank_if.sv | 27 ++
 rtl/ff_cell.sv | 63 ++++++
 rtl/jk_reg_bank.sv | 56 +++++
 tb/tb_jk_reg_bank.sv | 127 ++++++++++++
 5 files changed

// File: rtl/ff_pkg.sv
// Shared definitions for the flip-flop register bank: mode encodings and mode type.
package ff_pkg;

    typedef logic [1:0] ff_mode_t;

    localparam ff_mode_t MODE_D  = 2'd0;
    localparam ff_mode_t MODE_T  = 2'd1;
    localparam ff_mode_t MODE_JK = 2'd2;
    localparam ff_mode_t MODE_SR = 2'd3;

endpackage

// File: rtl/jk_reg_bank_if.sv
// Control/data bundle between a requester and the jk_reg_bank register bank.
interface jk_reg_bank_if
    import ff_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    ff_mode_t         mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] chg;
    logic             err;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qbar, chg, err
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qbar, chg, err
    );

endinterface

// File: rtl/ff_cell.sv
// One bit of the register bank: mode-selected next-state logic, state flop and change strobe.
module ff_cell
    import ff_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  ff_mode_t mode,
    input  logic     a,
    input  logic     b,
    input  logic     rst_val,
    output logic     q,
    output logic     chg,
    output logic     conflict
);

    logic q_q, q_d;
    logic chg_q, chg_d;

    always_comb begin
        q_d      = q_q;
        conflict = 1'b0;
        if (en) begin
            case (mode)
                MODE_D:  q_d = a;
                MODE_T:  q_d = q_q ^ a;
                MODE_JK: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                MODE_SR: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        default: q_d = q_q;
                    endcase
                    // S=R=1 holds the bit but is reported upward
                    conflict = a & b;
                end
                default: q_d = q_q;
            endcase
        end
        chg_d = q_d ^ q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= rst_val;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit multi-mode (D/T/JK/SR) register bank with change strobes and sticky SR-conflict flag.
module jk_reg_bank
    import ff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    jk_reg_bank_if.slave    bus
);

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] chg_vec;
    logic [WIDTH-1:0] conflict;
    logic             err_q, err_d;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        ff_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en),
            .mode     (bus.mode),
            .a        (bus.a[i]),
            .b        (bus.b[i]),
            .rst_val  (RESET_VAL[i]),
            .q        (q_vec[i]),
            .chg      (chg_vec[i]),
            .conflict (conflict[i])
        );
    end

    // A fresh conflict takes priority over a clear request on the same edge
    always_comb begin
        err_d = err_q;
        if (|conflict) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.q    = q_vec;
    assign bus.qbar = ~q_vec;
    assign bus.chg  = chg_vec;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed and randomized checks of jk_reg_bank against a characteristic-equation model.
module tb_jk_reg_bank;
    import ff_pkg::*;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] mq   = '0;
    logic [W-1:0] mchg = '0;
    logic         merr = 1'b0;

    jk_reg_bank_if #(.WIDTH(W)) bus ();

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: characteristic equations applied to whole vectors
    function automatic logic [W-1:0] model_next(input logic [1:0] m, input logic [W-1:0] q,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        case (m)
            2'd0:    return a;
            2'd1:    return q ^ a;
            2'd2:    return (a & ~q) | (~b & q);
            default: return (a & ~b) | (q & ~(~a & b));
        endcase
    endfunction

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                        input string tag);
        logic [W-1:0] nq;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.mode    = ff_mode_t'(m);
        bus.a       = av;
        bus.b       = bv;
        bus.clr_err = c;
        @(posedge clk);
        #1;
        if (r) begin
            mq = RV; mchg = '0; merr = 1'b0;
        end else if (e) begin
            nq   = model_next(m, mq, av, bv);
            mchg = nq ^ mq;
            mq   = nq;
            if (m == 2'd3 && (av & bv) != '0) merr = 1'b1;
            else if (c)                       merr = 1'b0;
        end else begin
            mchg = '0;
            if (c) merr = 1'b0;
        end
        chk({tag, ".q"},    bus.q,    mq);
        chk({tag, ".qbar"}, bus.qbar, ~mq);
        chk({tag, ".chg"},  bus.chg,  mchg);
        chk({tag, ".err"},  W'(bus.err), W'(merr));
    endtask

    initial begin
        bus.en = 1'b0; bus.mode = MODE_D; bus.a = '0; bus.b = '0; bus.clr_err = 1'b0;

        step(1, 0, 0, 8'h00, 8'h00, 0, "reset");
        chk("reset_const", bus.q, 8'hA5);

        // D then T, then strobe must drop
        step(0, 1, 0, 8'h00, 8'h00, 0, "d_zero");
        step(0, 1, 0, 8'h3C, 8'h00, 0, "d_3c");
        chk("d_3c_const", bus.q, 8'h3C);
        step(0, 1, 1, 8'hFF, 8'h00, 0, "t_ff");
        chk("t_ff_const", bus.q, 8'hC3);
        step(0, 0, 1, 8'hFF, 8'h00, 0, "chg_drop");

        // JK: every (j,k) combination against both starting values
        step(0, 1, 0, 8'h0F, 8'h00, 0, "d_0f");
        step(0, 1, 2, 8'hCC, 8'hAA, 0, "jk_all");
        chk("jk_all_const", bus.q, 8'hC5);

        // SR conflict and sticky err
        step(0, 1, 0, 8'h00, 8'h00, 0, "d_clear");
        step(0, 1, 3, 8'h81, 8'h01, 0, "sr_conf");
        chk("sr_conf_const", bus.q, 8'h80);
        for (int i = 0; i < 3; i++) step(0, 0, 3, 8'h00, 8'h00, 0, "err_hold");
        step(0, 1, 3, 8'h01, 8'h01, 1, "clr_vs_conf");
        step(0, 0, 3, 8'h00, 8'h00, 1, "clr_alone");

        // Enable gating
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'hFF, 8'h00, 0, "gated");

        // Reset mid-sequence with err pending
        step(0, 1, 3, 8'h10, 8'h10, 0, "pre_err");
        step(0, 1, 1, 8'hFF, 8'h00, 0, "tog1");
        step(0, 1, 1, 8'hFF, 8'h00, 0, "tog2");
        step(1, 1, 1, 8'hFF, 8'h00, 0, "mid_rst");
        step(0, 1, 1, 8'hFF, 8'h00, 0, "tog_resume");
        chk("tog_resume_const", bus.q, 8'h5A);
        step(0, 1, 1, 8'hFF, 8'h00, 0, "tog_resume2");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                 ($urandom_range(0, 7) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
